// File: rtl/inert_spi_serf_if.sv
// SPI pin bundle between an SPI master and the inertial-sensor responder.
// Carries SS_n/SCLK/MOSI from master, MISO and the INT data-ready line back.
// master modport drives the bus, slave modport is used by inert_spi_serf.
interface inert_spi_serf_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;
    logic INT;

    modport master (output SS_n, output SCLK, output MOSI, input MISO, input INT);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO, output INT);
endinterface

// File: rtl/inert_spi_serf.sv
// Inertial-sensor SPI responder: 16-bit frames, RW config regs, RO sample regs, INT.
// Latency: SPI pins resync over SYNC_STAGES+1 clk; writes/read side-effects commit 1 clk after SS_n rise.
// No backpressure: smpl_vld is always accepted (buffered while a sample read is locked).
// Ports: clk, rst_n (sync, active low); spi (slave modport: SS_n, SCLK, MOSI, MISO, INT);
//        smpl_vld/ptch_rt_smpl/AZ_smpl sample load; cfg_done config-complete; err sticky error.
// Optional feature: define INERT_SERF_ERR_EN to enable the sticky illegal-access flag on err.
module inert_spi_serf #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] PTCH_RST    = 16'h0000,
    parameter logic [15:0] AZ_RST      = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    inert_spi_serf_if.slave        spi,
    input  logic                   smpl_vld,
    input  logic [15:0]            ptch_rt_smpl,
    input  logic [15:0]            AZ_smpl,
    output logic                   cfg_done,
    output logic                   err
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // ---------------- pin synchronisers + edge detect ----------------
    logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
    logic                   ss_d, sclk_d;
    logic                   ss_s, sclk_s, mosi_s;
    logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;

    // SS_n chain resets low so a fall is only seen after SS_n has really been
    // observed high; a frame already in progress at reset is never picked up.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_sync   <= '0;
            ss_d      <= 1'b0;
            sclk_sync <= '1;
            sclk_d    <= 1'b1;
            mosi_sync <= '0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi.SS_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
            ss_d      <= ss_s;
            sclk_d    <= sclk_s;
        end
    end

    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_fall   = ss_d & ~ss_s;
    assign ss_rise   = ~ss_d & ss_s;
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;

    // ---------------- frame FSM / shifters ----------------
    logic [1:0]  state;
    logic [4:0]  bit_cnt;
    logic [15:0] rx_sr, tx_sr;
    logic [6:0]  rd_addr;
    logic [7:0]  rd_dat;
    logic [7:0]  int1_ctrl, ctrl1_xl, ctrl2_g, ctrl3_c;
    logic [15:0] ptch_q, az_q;

    // Address as it stands once the 8th bit arrives: rx_sr[5:0] holds addr[6:1].
    assign rd_addr = {rx_sr[5:0], mosi_s};

    always_comb begin
        rd_dat = 8'h00;
        case (rd_addr)
            7'h0D:   rd_dat = int1_ctrl;
            7'h10:   rd_dat = ctrl1_xl;
            7'h11:   rd_dat = ctrl2_g;
            7'h14:   rd_dat = ctrl3_c;
            7'h22:   rd_dat = ptch_q[7:0];
            7'h23:   rd_dat = ptch_q[15:8];
            7'h2C:   rd_dat = az_q[7:0];
            7'h2D:   rd_dat = az_q[15:8];
            default: rd_dat = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_cnt <= 5'd0;
            rx_sr   <= 16'h0000;
            tx_sr   <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= 5'd0;
                        rx_sr   <= 16'h0000;
                        tx_sr   <= 16'h0000;
                    end
                end
                ST_SHIFT: begin
                    if (ss_rise) begin
                        state <= (bit_cnt == 5'd16) ? ST_DONE : ST_IDLE;
                    end else if (sclk_rise) begin
                        rx_sr <= {rx_sr[14:0], mosi_s};
                        if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
                        // After 7 falls, frame bits 7:0 sit at tx_sr[14:7]; the
                        // 8th fall then presents reg bit 7 for the 9th rise.
                        if (bit_cnt == 5'd7) tx_sr <= {1'b0, rd_dat, 7'b0};
                    end else if (sclk_fall) begin
                        tx_sr <= {tx_sr[14:0], 1'b0};
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign spi.MISO = (state == ST_SHIFT) & tx_sr[15];

    // ---------------- frame decode ----------------
    logic       done;
    logic       f_rd;
    logic [6:0] f_addr;
    logic [7:0] f_wdat;
    logic       lock_set, lock_clr;

    assign done     = (state == ST_DONE);
    assign f_rd     = rx_sr[15];
    assign f_addr   = rx_sr[14:8];
    assign f_wdat   = rx_sr[7:0];
    assign lock_set = done & f_rd & (f_addr == 7'h22);
    assign lock_clr = done & f_rd & (f_addr == 7'h2D);

    logic [3:0] wr_seen;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            int1_ctrl <= 8'h00;
            ctrl1_xl  <= 8'h00;
            ctrl2_g   <= 8'h00;
            ctrl3_c   <= 8'h00;
            wr_seen   <= 4'b0000;
        end else if (done && !f_rd) begin
            case (f_addr)
                7'h0D: begin int1_ctrl <= f_wdat; wr_seen[0] <= 1'b1; end
                7'h10: begin ctrl1_xl  <= f_wdat; wr_seen[1] <= 1'b1; end
                7'h11: begin ctrl2_g   <= f_wdat; wr_seen[2] <= 1'b1; end
                7'h14: begin ctrl3_c   <= f_wdat; wr_seen[3] <= 1'b1; end
                default: ;
            endcase
        end
    end

    assign cfg_done = &wr_seen;

    // ---------------- sample snapshot / INT ----------------
    logic [15:0] pend_ptch, pend_az;
    logic        pend_full, lock, smpl_loaded, int_flag;
    logic        held;

    // Lock still in force this clk (a release in the same clk lets new data through).
    assign held = lock & ~lock_clr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptch_q      <= PTCH_RST;
            az_q        <= AZ_RST;
            pend_ptch   <= PTCH_RST;
            pend_az     <= AZ_RST;
            pend_full   <= 1'b0;
            lock        <= 1'b0;
            smpl_loaded <= 1'b0;
            int_flag    <= 1'b0;
        end else begin
            smpl_loaded <= 1'b0;
            if (smpl_vld && held) begin
                pend_ptch <= ptch_rt_smpl;
                pend_az   <= AZ_smpl;
                pend_full <= 1'b1;
            end else if (smpl_vld) begin
                ptch_q      <= ptch_rt_smpl;
                az_q        <= AZ_smpl;
                pend_full   <= 1'b0;
                smpl_loaded <= 1'b1;
            end else if (lock_clr && pend_full) begin
                ptch_q      <= pend_ptch;
                az_q        <= pend_az;
                pend_full   <= 1'b0;
                smpl_loaded <= 1'b1;
            end

            if (lock_set)      lock <= 1'b1;
            else if (lock_clr) lock <= 1'b0;

            if (smpl_loaded)   int_flag <= 1'b1;
            else if (lock_set) int_flag <= 1'b0;
        end
    end

    assign spi.INT = int_flag & int1_ctrl[1];

    // ---------------- illegal-access flag ----------------
`ifdef INERT_SERF_ERR_EN
    logic addr_rw, addr_ro, abort, err_q;

    assign addr_rw = (f_addr == 7'h0D) | (f_addr == 7'h10) | (f_addr == 7'h11) | (f_addr == 7'h14);
    assign addr_ro = (f_addr == 7'h22) | (f_addr == 7'h23) | (f_addr == 7'h2C) | (f_addr == 7'h2D);
    assign abort   = (state == ST_SHIFT) & ss_rise & (bit_cnt != 5'd16);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (abort || (done && !f_rd && !addr_rw) ||
                     (done && f_rd && !addr_rw && !addr_ro)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
